// File: rtl/rvfi_order_buffer_pkg.sv
// ============================================================================
// rvfi_order_buffer_pkg : shared RVFI order width and payload packing layout
// Revision: 1.0
// ============================================================================
`default_nettype none

package rvfi_order_buffer_pkg;

    localparam int ORDER_W = 64;

    // Check modules unpack the opaque payload with this same layout.
    typedef struct packed {
        logic [31:0] insn;
        logic [63:0] pc_rdata;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic        trap;
        logic [63:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_wmask;
        logic [11:0] csr_addr;
        logic [31:0] reserved;
    } rvfi_payload_t;

    localparam int PAYLOAD_W = $bits(rvfi_payload_t);

    function automatic int payload_width();
        return PAYLOAD_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rvfi_order_buffer.sv
// ============================================================================
// rvfi_order_buffer : reorders out-of-order RVFI retirements into order sequence
// Revision: 1.0
// ============================================================================
`default_nettype none

module rvfi_order_buffer
    import rvfi_order_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = PAYLOAD_W
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               in_valid,
    input  logic [ORDER_W-1:0] in_order,
    input  logic [PW-1:0]      in_data,
    input  logic [ORDER_W-1:0] check_order,
    output logic               out_valid,
    output logic [ORDER_W-1:0] out_order,
    output logic [PW-1:0]      out_data,
    output logic               check,
    output logic               err
);

    localparam int               c_idx_w     = $clog2(DEPTH);
    localparam logic [ORDER_W:0] c_depth_ext = (ORDER_W + 1)'(DEPTH);

    logic [DEPTH-1:0]   r_slot_valid;
    logic [ORDER_W-1:0] r_slot_order [DEPTH];
    logic [PW-1:0]      r_slot_data  [DEPTH];
    logic [ORDER_W-1:0] r_next_order;

    logic [c_idx_w-1:0] w_in_idx;
    logic [c_idx_w-1:0] w_head;
    logic [ORDER_W:0]   w_in_ext;
    logic [ORDER_W:0]   w_next_ext;
    logic               w_in_window;
    logic               w_accept;
    logic               w_violation;
    logic               w_emit;
    logic [DEPTH-1:0]   w_set_mask;
    logic [DEPTH-1:0]   w_clr_mask;

    assign w_in_idx   = in_order[c_idx_w-1:0];
    assign w_head     = r_next_order[c_idx_w-1:0];

    // One extra bit keeps next_order+DEPTH from wrapping near 2^64.
    assign w_in_ext    = {1'b0, in_order};
    assign w_next_ext  = {1'b0, r_next_order};
    assign w_in_window = (w_in_ext >= w_next_ext) && (w_in_ext < (w_next_ext + c_depth_ext));

    assign w_accept    = in_valid && w_in_window && !r_slot_valid[w_in_idx];
    assign w_violation = in_valid && !w_accept;
    assign w_emit      = r_slot_valid[w_head];

    assign w_set_mask  = w_accept ? (DEPTH'(1) << w_in_idx) : '0;
    assign w_clr_mask  = w_emit   ? (DEPTH'(1) << w_head)   : '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_slot_valid <= '0;
            r_next_order <= '0;
            out_valid    <= 1'b0;
            out_order    <= '0;
            out_data     <= '0;
            err          <= 1'b0;
        end else begin
            // Insert and emit never target the same slot, so set wins trivially.
            r_slot_valid <= (r_slot_valid & ~w_clr_mask) | w_set_mask;
            out_valid    <= w_emit;
            if (w_emit) begin
                out_order    <= r_slot_order[w_head];
                out_data     <= r_slot_data[w_head];
                r_next_order <= r_next_order + 1'b1;
            end
            if (w_violation) begin
                err <= 1'b1;
            end
        end
    end

    // Slot contents are qualified by r_slot_valid and need no reset.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_slot_order[w_in_idx] <= in_order;
            r_slot_data[w_in_idx]  <= in_data;
        end
    end

    assign check = out_valid && (out_order == check_order);

endmodule

`default_nettype wire

// File: tb/tb_rvfi_order_buffer.sv
// ============================================================================
// tb_rvfi_order_buffer : table-driven directed bench for rvfi_order_buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rvfi_order_buffer;

    localparam int PW = 256;

    logic          clock;
    logic          resetn;
    logic          in_valid;
    logic [63:0]   in_order;
    logic [PW-1:0] in_data;
    logic [63:0]   check_order;
    logic          out_valid;
    logic [63:0]   out_order;
    logic [PW-1:0] out_data;
    logic          check;
    logic          err;

    int checks = 0;
    int errors = 0;

    rvfi_order_buffer #(.DEPTH(4), .PW(PW)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_order    (in_order),
        .in_data     (in_data),
        .check_order (check_order),
        .out_valid   (out_valid),
        .out_order   (out_order),
        .out_data    (out_data),
        .check       (check),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          start;
        logic [63:0] chk;
        bit          vld;
        logic [63:0] ord;
        int          tag;
        bit          e_ov;
        logic [63:0] e_oo;
        int          e_tag;
        bit          e_chk;
        bit          e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [PW-1:0] mk_data(logic [63:0] o, int tag);
        return {o, ~o, o ^ 64'h5A5A_C3C3_0F0F_9669, 64'(tag) + 64'h1000};
    endfunction

    function automatic void add(bit start, logic [63:0] chk, bit vld, logic [63:0] ord, int tag,
                                bit e_ov, logic [63:0] e_oo, int e_tag, bit e_chk, bit e_err);
        vec_t v;
        v.start = start; v.chk = chk; v.vld = vld; v.ord = ord; v.tag = tag;
        v.e_ov = e_ov; v.e_oo = e_oo; v.e_tag = e_tag; v.e_chk = e_chk; v.e_err = e_err;
        vecs.push_back(v);
    endfunction

    task automatic cmp(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(bit v, logic [63:0] o, int tag);
        in_valid = v;
        in_order = v ? o : 64'd0;
        in_data  = v ? mk_data(o, tag) : '0;
    endtask

    initial begin
        resetn      = 1'b0;
        in_valid    = 1'b0;
        in_order    = '0;
        in_data     = '0;
        check_order = 64'd99;
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        // in-order stream, check_order=2 (check must drop when out_valid falls)
        add(1, 2, 1, 0, 0,  0, 0, 0, 0, 0);
        add(0, 2, 1, 1, 0,  0, 0, 0, 0, 0);
        add(0, 2, 1, 2, 0,  1, 0, 0, 0, 0);
        add(0, 2, 0, 0, 0,  1, 1, 0, 0, 0);
        add(0, 2, 0, 0, 0,  1, 2, 0, 1, 0);
        add(0, 2, 0, 0, 0,  0, 2, 0, 0, 0);
        // reversed window
        add(1, 99, 1, 3, 0, 0, 0, 0, 0, 0);
        add(0, 99, 1, 2, 0, 0, 0, 0, 0, 0);
        add(0, 99, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 99, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 99, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 99, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 99, 0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 99, 0, 0, 0, 1, 2, 0, 0, 0);
        add(0, 99, 0, 0, 0, 1, 3, 0, 0, 0);
        add(0, 99, 0, 0, 0, 0, 3, 0, 0, 0);
        // out of window (order == next_order+DEPTH)
        add(1, 99, 1, 4, 0, 0, 0, 0, 0, 0);
        add(0, 99, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 99, 1, 0, 0, 0, 0, 0, 0, 1);
        add(0, 99, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 99, 0, 0, 0, 1, 0, 0, 0, 1);
        add(0, 99, 0, 0, 0, 0, 0, 0, 0, 1);
        // duplicate order 1, first payload wins
        add(1, 99, 1, 1, 7, 0, 0, 0, 0, 0);
        add(0, 99, 1, 1, 8, 0, 0, 0, 0, 0);
        add(0, 99, 1, 0, 3, 0, 0, 0, 0, 1);
        add(0, 99, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 99, 0, 0, 0, 1, 0, 3, 0, 1);
        add(0, 99, 0, 0, 0, 1, 1, 7, 0, 1);
        add(0, 99, 0, 0, 0, 0, 1, 0, 0, 1);
        // upper window edge accepted after slot reuse, then stale order rejected
        add(1, 99, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 99, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 99, 1, 4, 0, 1, 0, 0, 0, 0);
        add(0, 99, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 99, 0, 0, 0, 0, 0, 0, 0, 1);
        // maximum order value is far outside the window
        add(1, 99, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0, 0);
        add(0, 99, 0, 0, 0, 0, 0, 0, 0, 1);
        // check pulse with check_order=2
        add(1, 2, 1, 0, 0,  0, 0, 0, 0, 0);
        add(0, 2, 1, 1, 0,  0, 0, 0, 0, 0);
        add(0, 2, 1, 2, 0,  1, 0, 0, 0, 0);
        add(0, 2, 1, 3, 0,  1, 1, 0, 0, 0);
        add(0, 2, 0, 0, 0,  1, 2, 0, 1, 0);
        add(0, 2, 0, 0, 0,  1, 3, 0, 0, 0);
        add(0, 2, 0, 0, 0,  0, 3, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clock);
            if (vecs[i].start) begin
                drive(0, 0, 0);
                resetn = 1'b0;
                #1;
                resetn = 1'b1;
            end
            check_order = vecs[i].chk;
            #1;
            cmp($sformatf("row%0d out_valid", i), PW'(out_valid), PW'(vecs[i].e_ov));
            cmp($sformatf("row%0d out_order", i), PW'(out_order), PW'(vecs[i].e_oo));
            if (vecs[i].e_ov)
                cmp($sformatf("row%0d out_data", i), out_data, mk_data(vecs[i].e_oo, vecs[i].e_tag));
            else if (vecs[i].start)
                cmp($sformatf("row%0d out_data_rst", i), out_data, '0);
            cmp($sformatf("row%0d check", i), PW'(check), PW'(vecs[i].e_chk));
            cmp($sformatf("row%0d err", i), PW'(err), PW'(vecs[i].e_err));
            drive(vecs[i].vld, vecs[i].ord, vecs[i].tag);
        end

        // reset mid-operation with err set, an output valid and order 2 buffered
        @(negedge clock);
        drive(0, 0, 0);
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        check_order = 64'd99;
        drive(1, 9, 0);
        @(negedge clock); drive(1, 0, 5);
        @(negedge clock); drive(1, 2, 0);
        @(negedge clock); drive(0, 0, 0);
        #1;
        cmp("midrst pre out_valid", PW'(out_valid), PW'(1'b1));
        cmp("midrst pre err", PW'(err), PW'(1'b1));
        #1;
        resetn = 1'b0;
        #1;
        cmp("midrst out_valid", PW'(out_valid), PW'(1'b0));
        cmp("midrst err", PW'(err), PW'(1'b0));
        cmp("midrst out_order", PW'(out_order), '0);
        cmp("midrst out_data", out_data, '0);
        resetn = 1'b1;
        @(negedge clock); drive(1, 0, 11);
        #1 cmp("midrst c0 out_valid", PW'(out_valid), PW'(1'b0));
        @(negedge clock); drive(0, 0, 0);
        #1 cmp("midrst c1 out_valid", PW'(out_valid), PW'(1'b0));
        @(negedge clock); drive(1, 1, 12);
        #1;
        cmp("midrst c2 out_valid", PW'(out_valid), PW'(1'b1));
        cmp("midrst c2 out_order", PW'(out_order), '0);
        cmp("midrst c2 out_data", out_data, mk_data(64'd0, 11));
        @(negedge clock); drive(0, 0, 0);
        #1 cmp("midrst c3 out_valid", PW'(out_valid), PW'(1'b0));
        @(negedge clock);
        #1;
        cmp("midrst c4 out_order", PW'(out_order), PW'(64'd1));
        @(negedge clock);
        #1;
        cmp("midrst c5 out_valid", PW'(out_valid), PW'(1'b0));
        cmp("midrst c5 err", PW'(err), PW'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
